// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and format encodings for the stereo DAC transmitter.
// Exports SLOT_W/FRAME_SLOTS/FRAME_W geometry and the fmt_e format codes.
package dac_pkg;

    localparam int SLOT_W      = 32;
    localparam int FRAME_SLOTS = 2;
    localparam int FRAME_W     = SLOT_W * FRAME_SLOTS;

    typedef enum logic [1:0] {
        FMT_RJ  = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_I2S = 2'd2
    } fmt_e;

endpackage

// File: rtl/dac_fifo.sv
// dac_fifo: synchronous frame FIFO holding stereo pairs for the DAC path.
// Ports: clk, rst, push/wdata, pop/rdata (show-ahead), full, empty, level.
module dac_fifo
    import dac_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_tx.sv
// dac_tx: stereo serial-audio transmitter (RJ / LJ / I2S) with frame FIFO.
// Ports: in_l/in_r/in_valid/in_ready sample input, fmt, underrun/underrun_clr,
// level, and the DAC pins mclk, bclk, lrck, sdti.
module dac_tx
    import dac_pkg::*;
#(
    parameter int SAMPLE_W      = 20,
    parameter int MCLK_DIV_LOG2 = 2,
    parameter int BCLK_DIV_LOG2 = 4,
    parameter int FIFO_DEPTH    = 4,
    localparam int LW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    output logic                underrun,
    input  logic                underrun_clr,
    output logic [LW-1:0]       level,
    output logic                mclk,
    output logic                bclk,
    output logic                lrck,
    output logic                sdti
);

    localparam int T  = BCLK_DIV_LOG2 + 6;
    localparam int P  = SLOT_W - SAMPLE_W;
    localparam int PW = 2 * SAMPLE_W;

    logic [T-1:0]       t;
    logic [FRAME_W-1:0] sr;
    logic               load;
    logic               shift;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [PW-1:0]      head;
    logic [SLOT_W-1:0]  slot_l;
    logic [SLOT_W-1:0]  slot_r;

    // Right-justified is the base layout; LJ and I2S are left shifts of it.
    // Code 3 falls through to right-justified.
    function automatic logic [SLOT_W-1:0] fmt_slot(
        input logic [SAMPLE_W-1:0] s,
        input logic [1:0]          f
    );
        logic [SLOT_W-1:0] rj;
        logic [SLOT_W-1:0] res;
        rj = {{P{1'b0}}, s};
        unique case (1'b1)
            (f == FMT_LJ):  res = rj << P;
            (f == FMT_I2S): res = rj << (P - 1);
            default:        res = rj;
        endcase
        return res;
    endfunction

    dac_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_l, in_r}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign load     = &t;
    assign shift    = (&t[BCLK_DIV_LOG2-1:0]) && !load;
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = load && !empty;

    always_comb begin
        slot_l = fmt_slot(head[PW-1:SAMPLE_W], fmt);
        slot_r = fmt_slot(head[SAMPLE_W-1:0], fmt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t        <= '0;
            sr       <= '0;
            underrun <= 1'b0;
        end else begin
            t <= t + T'(1);
            if (load) begin
                sr <= empty ? '0 : {slot_l, slot_r};
            end else if (shift) begin
                sr <= {sr[FRAME_W-2:0], 1'b0};
            end
            // A fresh underrun outranks a coincident clear.
            if (load && empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    assign mclk = t[MCLK_DIV_LOG2-1];
    assign bclk = t[BCLK_DIV_LOG2-1];
    assign lrck = t[T-1];
    assign sdti = sr[FRAME_W-1];

endmodule
